// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF-stage bus bundling imem, hazard/redirect and IF/ID signals
//   master: the fetch stage (drives pc_out, IF/ID, status; receives ir_in and controls)
//   slave : surrounding pipeline / memory / hazard unit
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] ir_in;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic        exc_misalign;
    modport master (
        output pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count, halted, exc_misalign,
        input  ir_in, stall, flush, br_taken, br_target, jmp_taken, jmp_target
    );
    modport slave (
        input  pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count, halted, exc_misalign,
        output ir_in, stall, flush, br_taken, br_target, jmp_taken, jmp_target
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC and the IF/ID register
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master (imem pc_out/ir_in, stall/flush, branch/jump
//              redirects, IF/ID outputs, fetch_count, halted, exc_misalign)
//   MISALIGN_TRAP_EN : when defined, misaligned redirects go to TRAP_VECTOR
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter int          IMEM_WORDS  = 128,
    parameter logic [31:0] TRAP_VECTOR = 32'h00000180
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam logic [31:0] PC_END = 32'(4 * IMEM_WORDS);

    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d;
    logic        valid_q, valid_d, halt_q, halt_d, exc_q, exc_d;
    logic [31:0] pc4, tgt_raw, tgt;
    logic        redir, mis, oob;

    assign tgt_raw = bus.br_taken ? bus.br_target : bus.jmp_target;
    assign redir   = bus.br_taken | bus.jmp_taken;
`ifdef MISALIGN_TRAP_EN
    assign mis = redir & (|tgt_raw[1:0]);
    assign tgt = mis ? TRAP_VECTOR : tgt_raw;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, tgt_raw[1:0], TRAP_VECTOR};
    assign mis = 1'b0;
    assign tgt = {tgt_raw[31:2], 2'b00};
`endif
    assign pc4 = pc_q + 32'd4;
    // Out-of-range is tested on the current PC, so a wrapped PC+4 never executes past the end
    assign oob = halt_q | (pc_q >= PC_END);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        exc_d   = mis;
        if (redir) begin
            pc_d    = tgt;
            instr_d = '0;
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (oob) begin
            instr_d = '0;
            valid_d = 1'b0;
            halt_d  = 1'b1;
        end else if (bus.stall) begin
            instr_d = bus.flush ? '0 : instr_q;
            valid_d = bus.flush ? 1'b0 : valid_q;
        end else if (bus.flush) begin
            pc_d    = pc4;
            instr_d = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc4;
            instr_d = bus.ir_in;
            pc4_d   = pc4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + {31'd0, cnt_q != '1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.ifid_instr   = instr_q;
    assign bus.ifid_pc4     = pc4_q;
    assign bus.ifid_valid   = valid_q;
    assign bus.fetch_count  = cnt_q;
    assign bus.halted       = halt_q;
    assign bus.exc_misalign = exc_q;
endmodule
